instr_stream_encoder: RTL and testbench

- Encoder counterpart to the opcode decoder: packs instruction field records into 32-bit RV32I words, one per handshake.
- Emits only the opcodes the datapath decodes: R, I-ALU, LOAD, STORE, BRANCH, JAL, LUI.
- Sits between a test or program generator and instruction memory. Streams words with byte addresses through a registered valid/ready output stage and a RUN/DONE/HALT control FSM.

---
 rtl/instr_stream_encoder.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_instr_stream_encoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder
//   Packs instruction field records into RV32I words (R, I-ALU, LOAD, STORE,
//   BRANCH, JAL, LUI) and streams them, with byte addresses, through a
//   registered valid/ready output stage. A small IDLE/RUN/DONE/HALT FSM
//   frames each stream between a start pulse and the in_last record.
//
//   Build option: define ENC_IMM_RANGE_CHECK_EN to reject records whose
//   immediate does not fit the target format. Without it, out-of-range
//   immediate bits are truncated and only class 7 is illegal.
module instr_stream_encoder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              illegal_err,
  output logic [CNT_W-1:0]  instr_count
);

  // Record classes
  localparam logic [2:0] C_R      = 3'd0;
  localparam logic [2:0] C_IALU   = 3'd1;
  localparam logic [2:0] C_LOAD   = 3'd2;
  localparam logic [2:0] C_STORE  = 3'd3;
  localparam logic [2:0] C_BRANCH = 3'd4;
  localparam logic [2:0] C_JAL    = 3'd5;
  localparam logic [2:0] C_LUI    = 3'd6;

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  // Output stage and stream bookkeeping
  logic                r_out_valid;
  logic [31:0]         r_out_instr;
  logic [ADDR_W-1:0]   r_out_addr;
  logic                r_out_last;
  logic [ADDR_W-1:0]   r_next_addr;
  logic [CNT_W-1:0]    r_count;
  logic                r_done;
  logic                r_illegal;
  logic                r_last_seen;

  // Handshake / control decode
  logic                w_in_ready;
  logic                w_busy;
  logic                w_start_new;
  logic                w_start_resume;
  logic                w_accept;
  logic                w_illegal;
  logic                w_range_bad;
  logic                w_accept_ok;
  logic                w_accept_bad;
  logic                w_out_hs;

  // Encoder datapath
  logic                w_is_shift;
  logic [11:0]         w_ialu_imm;
  logic [31:0]         w_enc_instr;

  // --------------------------------------------------------------------------
  // Handshake terms
  // --------------------------------------------------------------------------
  assign w_accept     = in_valid && w_in_ready;
  assign w_illegal    = (in_class == 3'd7) || w_range_bad;
  assign w_accept_ok  = w_accept && !w_illegal;
  assign w_accept_bad = w_accept && w_illegal;
  assign w_out_hs     = r_out_valid && out_ready;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a bad record halts immediately; the last record ends
  // the stream only once its word has actually left the output register.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_accept_bad) begin
          w_state_next = S_HALT;
        end else if (w_out_hs && r_out_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) w_state_next = S_RUN;
      end
      S_HALT: begin
        if (start) w_state_next = S_RUN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode: input side opens only in RUN, before in_last is taken,
  // and only when the output register is free or draining this cycle.
  always_comb begin
    w_in_ready     = 1'b0;
    w_busy         = r_out_valid;
    w_start_new    = 1'b0;
    w_start_resume = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_start_new = start;
      end
      S_RUN: begin
        w_in_ready = !r_last_seen && (!r_out_valid || out_ready);
        w_busy     = 1'b1;
      end
      S_HALT: begin
        w_start_resume = start;
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Encoder
  // --------------------------------------------------------------------------

  // Shift-immediate forms carry funct7[5] in imm[10] and a 5-bit shamt.
  assign w_is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // I-ALU immediate selection
  always_comb begin
    if (w_is_shift) begin
      w_ialu_imm = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0]};
    end else begin
      w_ialu_imm = in_imm[11:0];
    end
  end

  // Field packing per instruction format
  always_comb begin
    w_enc_instr = 32'h0000_0000;
    case (in_class)
      C_R: begin
        w_enc_instr = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1,
                       in_funct3, in_rd, OP_R};
      end
      C_IALU: begin
        w_enc_instr = {w_ialu_imm, in_rs1, in_funct3, in_rd, OP_IALU};
      end
      C_LOAD: begin
        w_enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      end
      C_STORE: begin
        w_enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:0], OP_STORE};
      end
      C_BRANCH: begin
        w_enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], OP_BRANCH};
      end
      C_JAL: begin
        w_enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                       in_rd, OP_JAL};
      end
      C_LUI: begin
        w_enc_instr = {in_imm[31:12], in_rd, OP_LUI};
      end
      default: begin
        w_enc_instr = 32'h0000_0000;
      end
    endcase
  end

`ifdef ENC_IMM_RANGE_CHECK_EN
  // Sign-extension checks: all bits above the format's sign bit must equal it.
  logic w_fits12;
  logic w_fits13;
  logic w_fits21;

  assign w_fits12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign w_fits13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
  assign w_fits21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

  // Flag immediates that the selected format cannot represent exactly.
  always_comb begin
    w_range_bad = 1'b0;
    case (in_class)
      C_IALU: begin
        if (w_is_shift) begin
          w_range_bad = (in_imm[11:5] != 7'd0);
        end else begin
          w_range_bad = !w_fits12;
        end
      end
      C_LOAD, C_STORE: begin
        w_range_bad = !w_fits12;
      end
      C_BRANCH: begin
        w_range_bad = !w_fits13 || in_imm[0];
      end
      C_JAL: begin
        w_range_bad = !w_fits21 || in_imm[0];
      end
      C_LUI: begin
        w_range_bad = (in_imm[11:0] != 12'd0);
      end
      default: begin
        w_range_bad = 1'b0;
      end
    endcase
  end
`else
  // Immediates are truncated silently; only the reserved class is rejected.
  assign w_range_bad = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------

  // Output register: load on a legal accept, otherwise empty on handshake.
  // Holds its contents unchanged while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0000_0000;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept_ok) begin
      r_out_valid <= 1'b1;
      r_out_instr <= w_enc_instr;
      r_out_addr  <= r_next_addr;
      r_out_last  <= in_last;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // Next byte address: reloaded by start, advances one word per legal accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_next_addr <= '0;
    end else if (w_start_new || w_start_resume) begin
      r_next_addr <= base_addr;
    end else if (w_accept_ok) begin
      r_next_addr <= r_next_addr + ADDR_W'(4);
    end
  end

  // Emitted-word counter: cleared when a fresh stream starts, wraps freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_start_new) begin
      r_count <= '0;
    end else if (w_out_hs) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // done rises with the final word's handshake and holds until restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
    end else if (w_start_new) begin
      r_done <= 1'b0;
    end else if ((r_state == S_RUN) && w_out_hs && r_out_last) begin
      r_done <= 1'b1;
    end
  end

  // Sticky illegal flag, cleared by any effective start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if (w_start_new || w_start_resume) begin
      r_illegal <= 1'b0;
    end else if (w_accept_bad) begin
      r_illegal <= 1'b1;
    end
  end

  // Close the input side once the final record has been taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_seen <= 1'b0;
    end else if (w_start_new || w_start_resume) begin
      r_last_seen <= 1'b0;
    end else if (w_accept && in_last) begin
      r_last_seen <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_addr    = r_out_addr;
  assign busy        = w_busy;
  assign done        = r_done;
  assign illegal_err = r_illegal;
  assign instr_count = r_count;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: the driver pushes the
// hand-computed word/address of every legal record it hands over, and an
// independent monitor pops and compares on each output handshake.
module tb_instr_stream_encoder;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        in_class;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;
  logic              illegal_err;
  logic [CNT_W-1:0]  instr_count;

  instr_stream_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_class    (in_class),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done),
    .illegal_err (illegal_err),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          hs_cyc[$];
  int          hs_total = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_addr = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h @ %h expected none", out_instr, out_addr);
      end else begin
        e = sb.pop_front();
        $display("word %h @ %h (expected %h @ %h)", out_instr, out_addr, e.instr, e.addr);
        check("word_instr", out_instr, e.instr);
        check("word_addr", out_addr, e.addr);
      end
      hs_cyc.push_back(cyc);
      hs_total++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b);
    start     = 1'b1;
    base_addr = b;
    tick();
    start     = 1'b0;
    exp_addr  = b;
  endtask

  // Present one record, wait (bounded) for acceptance, queue its expectation.
  task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic b5,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic last, input logic legal,
                      input logic [31:0] exp_instr);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_class    = cls;
    in_funct3   = f3;
    in_funct7b5 = b5;
    in_rd       = rd;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_last     = last;
    in_valid    = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      n++;
    end
    if (acc && legal) begin
      sb.push_back({exp_instr, exp_addr});
      exp_addr = exp_addr + 32'd4;
    end
    if (acc) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_class = '0; in_funct3 = '0; in_funct7b5 = 1'b0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_imm = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_illegal", {31'd0, illegal_err}, 0);
    check("rst_count", {16'd0, instr_count}, 0);
    reset = 1'b0;
    tick();

    // Back-to-back R then I-ALU from 0x100
    out_ready = 1'b1;
    do_start(32'h100);
    check("t1_busy", {31'd0, busy}, 1);
    check("t1_in_ready", {31'd0, in_ready}, 1);
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h002081B3);
    send(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFF00293);
    drain("t1_drain");
    check("t1_no_bubble", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2], 1);
    check("t1_count", {16'd0, instr_count}, 2);

    // Remaining formats
    send(3'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b1, 32'h0020A423);
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFE208EE3);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0, 1'b1, 32'h008000EF);
    send(3'd6, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b1, 32'h12345537);
    drain("t2_drain");
    check("t2_count", {16'd0, instr_count}, 6);

    // Consumer stall: word and address hold, input side closed
    out_ready = 1'b0;
    send(3'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b1, 32'h403100B3);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, out_valid}, 1);
      check("stall_instr", out_instr, 32'h403100B3);
      check("stall_addr", out_addr, 32'h118);
      check("stall_in_ready", {31'd0, in_ready}, 0);
      tick();
    end
    prev = hs_total;
    out_ready = 1'b1;
    drain("t3_drain");
    check("t3_one_hs", hs_total - prev, 1);
    check("t3_count", {16'd0, instr_count}, 7);

    // Final record of the first stream
    send(3'd2, 3'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'd16, 1'b1, 1'b1, 32'h01012203);
    drain("t3_last_drain");
    check("t3_done", {31'd0, done}, 1);
    check("t3_in_ready", {31'd0, in_ready}, 0);
    check("t3_busy", {31'd0, busy}, 0);
    check("t3_final_count", {16'd0, instr_count}, 8);

    // Address wrap at the top of the space
    do_start(32'hFFFFFFFC);
    check("t4_done_clr", {31'd0, done}, 0);
    check("t4_count_clr", {16'd0, instr_count}, 0);
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h002081B3);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 32'h00500093);
    drain("t4_drain");
    check("t4_done", {31'd0, done}, 1);
    check("t4_in_ready", {31'd0, in_ready}, 0);
    check("t4_count", {16'd0, instr_count}, 2);

    // Reserved class after a legal word
    do_start(32'h200);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093);
    send(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 1'b0, 32'h0);
    drain("t5_drain");
    check("t5_illegal", {31'd0, illegal_err}, 1);
    check("t5_in_ready", {31'd0, in_ready}, 0);
    check("t5_busy_halt", {31'd0, busy}, 0);
    check("t5_done", {31'd0, done}, 0);
    do_start(32'h300);
    check("t5_illegal_clr", {31'd0, illegal_err}, 0);
    check("t5_run_in_ready", {31'd0, in_ready}, 1);
`ifdef ENC_IMM_RANGE_CHECK_EN
    send(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h800, 1'b0, 1'b0, 32'h0);
    check("range_illegal", {31'd0, illegal_err}, 1);
    check("range_in_ready", {31'd0, in_ready}, 0);
    check("range_no_word", {31'd0, out_valid}, 0);
    do_start(32'h400);
`else
    send(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h800, 1'b0, 1'b1, 32'h80000293);
    drain("trunc_drain");
    check("trunc_illegal", {31'd0, illegal_err}, 0);
`endif

    // Reset with a word held in the output register
    out_ready = 1'b0;
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h002081B3);
    check("t6_held", {31'd0, out_valid}, 1);
    reset = 1'b1;
    tick();
    check("t6_out_valid", {31'd0, out_valid}, 0);
    check("t6_in_ready", {31'd0, in_ready}, 0);
    check("t6_count", {16'd0, instr_count}, 0);
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_illegal", {31'd0, illegal_err}, 0);
    sb.delete();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    do_start(32'h500);
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h002081B3);
    drain("t6_drain");
    check("t6_resume_count", {16'd0, instr_count}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
